// File: rtl/cv32e20_tb_pkg.sv
// rtl/cv32e20_tb_pkg.sv - shared types for the testbench RAM port arbiter
package cv32e20_tb_pkg;

  // Which core interface owns a RAM transaction.
  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } mm_requester_e;

  // The requester that gets priority after r has been served.
  function automatic mm_requester_e mm_other(input mm_requester_e r);
    return (r == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
  endfunction

endpackage

// File: rtl/mm_ram_port_arbiter_tag_fifo.sv
// rtl/mm_ram_port_arbiter_tag_fifo.sv - in-order requester-tag FIFO for outstanding RAM transactions
module mm_ram_tag_fifo
  import cv32e20_tb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  mm_requester_e tag_i,
  input  logic          pop_i,
  output mm_requester_e head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  mm_requester_e   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push_en, pop_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign pop_en  = pop_i & ~empty_o;
  assign push_en = push_i & (~full_o | pop_en);

  // Pointer advance with explicit wrap at DEPTH and occupancy tracking.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop_en)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (push_en & ~pop_en)      cnt_d = cnt_q + CW'(1);
    else if (pop_en & ~push_en) cnt_d = cnt_q - CW'(1);
  end

  // Control state; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Tag storage; contents are meaningless while empty so they are not reset.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= tag_i;
  end

endmodule

// File: rtl/mm_ram_port_arbiter.sv
// rtl/mm_ram_port_arbiter.sv - round-robin sharing of one RAM port between instr and data OBI ports
module mm_ram_port_arbiter
  import cv32e20_tb_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      instr_req_i,
  input  logic [31:0]               instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]     instr_rdata_o,
  input  logic                      data_req_i,
  input  logic [31:0]               data_addr_i,
  input  logic                      data_we_i,
  input  logic [DATA_WIDTH/8-1:0]   data_be_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [DATA_WIDTH-1:0]     data_rdata_o,
  output logic                      ram_req_o,
  input  logic                      ram_gnt_i,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic                      ram_we_o,
  output logic [DATA_WIDTH/8-1:0]   ram_be_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  input  logic                      ram_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i,
  output logic [CNT_WIDTH-1:0]      conflict_cnt_o,
  output logic                      protocol_err_o
);

  mm_requester_e        winner, last_winner_q, last_winner_d, head_tag;
  logic                 fifo_full, fifo_empty;
  logic                 can_push, both_req, accept, pop;
  logic [CNT_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;
  logic                 protocol_err_q, protocol_err_d;
  logic                 unused_addr_bits;

  // Upper address bits fall outside the RAM bank and are intentionally dropped.
  assign unused_addr_bits = ^{instr_addr_i[31:RAM_ADDR_WIDTH], data_addr_i[31:RAM_ADDR_WIDTH]};

  assign both_req  = instr_req_i & data_req_i;
  assign can_push  = ~fifo_full | ram_rvalid_i;
  assign ram_req_o = (instr_req_i | data_req_i) & can_push;
  assign accept    = ram_req_o & ram_gnt_i;
  assign pop       = ram_rvalid_i & ~fifo_empty;

  assign instr_gnt_o    = accept & (winner == REQ_INSTR);
  assign data_gnt_o     = accept & (winner == REQ_DATA);
  assign instr_rvalid_o = pop & (head_tag == REQ_INSTR);
  assign data_rvalid_o  = pop & (head_tag == REQ_DATA);
  assign instr_rdata_o  = ram_rdata_i;
  assign data_rdata_o   = ram_rdata_i;

  assign conflict_cnt_o = conflict_cnt_q;
  assign protocol_err_o = protocol_err_q;

  mm_ram_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .tag_i   (winner),
    .pop_i   (pop),
    .head_o  (head_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Pick the sole requester, or on conflict the one not served last.
  always_comb begin
    winner = REQ_INSTR;
    if (both_req)        winner = mm_other(last_winner_q);
    else if (data_req_i) winner = REQ_DATA;
  end

  // Steer the winner's request fields onto the RAM port; fetches are full-word reads.
  always_comb begin
    ram_addr_o  = instr_addr_i[RAM_ADDR_WIDTH-1:0];
    ram_we_o    = 1'b0;
    ram_be_o    = '1;
    ram_wdata_o = data_wdata_i;
    if (winner == REQ_DATA) begin
      ram_addr_o = data_addr_i[RAM_ADDR_WIDTH-1:0];
      ram_we_o   = data_we_i;
      ram_be_o   = data_be_i;
    end
  end

  // Next-state for round-robin history, saturating conflict counter and sticky error.
  always_comb begin
    last_winner_d  = last_winner_q;
    conflict_cnt_d = conflict_cnt_q;
    protocol_err_d = protocol_err_q;
    if (accept) last_winner_d = winner;
    if (both_req & can_push & (conflict_cnt_q != '1))
      conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
    if (ram_rvalid_i & fifo_empty) protocol_err_d = 1'b1;
  end

  // Arbiter state registers; reset favours DATA on the first conflict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_winner_q  <= REQ_INSTR;
      conflict_cnt_q <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      last_winner_q  <= last_winner_d;
      conflict_cnt_q <= conflict_cnt_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule

// File: tb/tb_mm_ram_port_arbiter.sv
// tb/tb_mm_ram_port_arbiter.sv - self-checking bench for mm_ram_port_arbiter
module tb_mm_ram_port_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          instr_req_i;
  logic [31:0]   instr_addr_i;
  logic          instr_gnt_o, instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i;
  logic [31:0]   data_addr_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o, data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          ram_req_o, ram_gnt_i;
  logic [AW-1:0] ram_addr_o;
  logic          ram_we_o;
  logic [3:0]    ram_be_o;
  logic [DW-1:0] ram_wdata_o;
  logic          ram_rvalid_i;
  logic [DW-1:0] ram_rdata_i;
  logic [CW-1:0] conflict_cnt_o;
  logic          protocol_err_o;

  always #5 clk_i = ~clk_i;

  mm_ram_port_arbiter #(
    .RAM_ADDR_WIDTH (AW),
    .DATA_WIDTH     (DW),
    .MAX_OUTSTANDING(MO),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .ram_req_o(ram_req_o), .ram_gnt_i(ram_gnt_i), .ram_addr_o(ram_addr_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o),
    .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i),
    .conflict_cnt_o(conflict_cnt_o), .protocol_err_o(protocol_err_o)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
  } resp_t;

  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    ram_lat = 1;
  int    n_acc = 0;
  int    last_due = 0;
  bit    spurious = 1'b0;
  bit    tagq[$];
  resp_t pend[$];
  bit    last_w;
  int    m_cnt;
  bit    m_err;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; instr_req_i = 1'b0; data_req_i = 1'b0; ram_rvalid_i = 1'b0; spurious = 1'b0;
    @(posedge clk_i); #1; cyc++;
    rst_i = 1'b0;
    tagq.delete(); pend.delete();
    last_w = 1'b0; m_cnt = 0; m_err = 1'b0; last_due = 0;
  endtask

  // Drive the RAM response side for this cycle, then let combinational outputs settle.
  task automatic pre();
    ram_rvalid_i = 1'b0;
    ram_rdata_i  = $urandom;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ram_rvalid_i = 1'b1;
      ram_rdata_i  = pend[0].d;
    end else if (spurious && pend.size() == 0) begin
      ram_rvalid_i = 1'b1;
    end
    #3;
  endtask

  // Compare against the reference model, advance it, and move to the next cycle.
  task automatic post();
    bit can, win, acc, real_rv;
    int due;
    can     = (tagq.size() < MO) || ram_rvalid_i;
    win     = (instr_req_i && data_req_i) ? !last_w : data_req_i;
    acc     = (instr_req_i || data_req_i) && can && ram_gnt_i;
    real_rv = ram_rvalid_i && tagq.size() > 0;
    check("ram_req", ram_req_o, (instr_req_i || data_req_i) && can);
    check("instr_gnt", instr_gnt_o, acc && !win);
    check("data_gnt", data_gnt_o, acc && win);
    check("instr_rvalid", instr_rvalid_o, real_rv && !tagq[0]);
    check("data_rvalid", data_rvalid_o, real_rv && tagq[0]);
    if (real_rv) check("rdata", tagq[0] ? data_rdata_o : instr_rdata_o, pend[0].d);
    check("conflict_cnt", conflict_cnt_o, m_cnt);
    check("protocol_err", protocol_err_o, m_err);
    if ((instr_req_i || data_req_i) && can) begin
      check("ram_addr", ram_addr_o, win ? data_addr_i[AW-1:0] : instr_addr_i[AW-1:0]);
      check("ram_we", ram_we_o, win ? data_we_i : 1'b0);
      check("ram_be", ram_be_o, win ? data_be_i : 4'hF);
      if (win) check("ram_wdata", ram_wdata_o, data_wdata_i);
    end
    if (ram_rvalid_i && !real_rv) m_err = 1'b1;
    if (real_rv) begin
      tagq.delete(0);
      pend.delete(0);
    end
    if (acc) begin
      tagq.push_back(win);
      last_w = win;
      due = cyc + ram_lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{due, $urandom});
      n_acc++;
    end
    if (instr_req_i && data_req_i && can && m_cnt < (1 << CW) - 1) m_cnt++;
    @(posedge clk_i); #1; cyc++;
  endtask

  task automatic idle(input int n);
    instr_req_i = 1'b0; data_req_i = 1'b0;
    for (int i = 0; i < n; i++) begin pre(); post(); end
  endtask

  initial begin
    int first_rv;
    rst_i = 1'b1; instr_req_i = 1'b0; instr_addr_i = '0; data_req_i = 1'b0; data_addr_i = '0;
    data_we_i = 1'b0; data_be_i = 4'h0; data_wdata_i = '0; ram_gnt_i = 1'b0;
    ram_rvalid_i = 1'b0; ram_rdata_i = '0;
    do_reset();

    // Instruction fetch alone, single-cycle RAM.
    ram_lat = 1; ram_gnt_i = 1'b1;
    instr_req_i = 1'b1; instr_addr_i = 32'h8000_0080;
    pre();
    check("t1_addr", ram_addr_o, 20'h00080);
    check("t1_gnt", instr_gnt_o, 1'b1);
    post();
    instr_req_i = 1'b0;
    pre();
    check("t1_rvalid", instr_rvalid_o, 1'b1);
    check("t1_no_data_rvalid", data_rvalid_o, 1'b0);
    post();
    idle(2);

    // Continuous conflict: strict alternation starting with DATA.
    do_reset();
    ram_lat = 1; ram_gnt_i = 1'b1;
    instr_req_i = 1'b1; data_req_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      instr_addr_i = $urandom; data_addr_i = $urandom; data_we_i = 1'b0; data_be_i = 4'hF;
      pre();
      check($sformatf("t2_data_gnt%0d", k), data_gnt_o, (k % 2) == 0);
      check($sformatf("t2_instr_gnt%0d", k), instr_gnt_o, (k % 2) == 1);
      post();
    end
    check("t2_cnt", conflict_cnt_o, 16'd6);
    idle(2);

    // RAM stalls with both requesting.
    do_reset();
    ram_gnt_i = 1'b0; instr_req_i = 1'b1; data_req_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pre();
      check("t3_req", ram_req_o, 1'b1);
      check("t3_no_gnt", instr_gnt_o | data_gnt_o, 1'b0);
      post();
    end
    check("t3_cnt", conflict_cnt_o, 16'd3);
    idle(1);

    // Outstanding limit with three-cycle RAM latency.
    do_reset();
    ram_lat = 3; ram_gnt_i = 1'b1; instr_req_i = 1'b1; data_req_i = 1'b0;
    n_acc = 0; first_rv = 0;
    for (int k = 0; k < 12; k++) begin
      instr_addr_i = $urandom;
      pre();
      if (ram_rvalid_i && first_rv == 0) begin
        check("t4_accepts_before_rv", n_acc, 2);
        check("t4_resume", instr_gnt_o, 1'b1);
        first_rv = 1;
      end
      post();
    end
    check("t4_saw_rvalid", first_rv, 1);
    idle(8);

    // Partial write, then a spurious response.
    do_reset();
    ram_lat = 1; ram_gnt_i = 1'b1;
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011; data_wdata_i = 32'hDEAD_BEEF;
    data_addr_i = 32'h0001_2344;
    pre();
    check("t5_we", ram_we_o, 1'b1);
    check("t5_be", ram_be_o, 4'b0011);
    post();
    data_req_i = 1'b0;
    pre();
    check("t5_data_rvalid", data_rvalid_o, 1'b1);
    post();
    spurious = 1'b1; idle(1); spurious = 1'b0;
    idle(3);
    check("t5_err_held", protocol_err_o, 1'b1);
    do_reset();
    check("t5_err_cleared", protocol_err_o, 1'b0);

    // Reset with two transactions in flight.
    ram_lat = 4; ram_gnt_i = 1'b1; instr_req_i = 1'b1;
    pre(); post(); pre(); post();
    do_reset();
    pre();
    check("t6_req", ram_req_o, 1'b0);
    check("t6_rvalid", instr_rvalid_o | data_rvalid_o, 1'b0);
    check("t6_cnt", conflict_cnt_o, 16'd0);
    post();
    ram_lat = 6; instr_req_i = 1'b1; n_acc = 0;
    for (int k = 0; k < 3; k++) begin pre(); post(); end
    check("t6_fifo_empty_after_reset", n_acc, 2);
    idle(8);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 500; k++) begin
      instr_req_i  = $urandom_range(0, 1);
      data_req_i   = $urandom_range(0, 1);
      instr_addr_i = $urandom;
      data_addr_i  = $urandom;
      data_we_i    = $urandom_range(0, 1);
      data_be_i    = 4'($urandom);
      data_wdata_i = $urandom;
      ram_gnt_i    = ($urandom_range(0, 3) != 0);
      ram_lat      = $urandom_range(1, 4);
      spurious     = ($urandom_range(0, 99) == 0);
      pre(); post();
    end
    spurious = 1'b0;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
